// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer: FSM states, access-size
// encoding and cache line geometry.
package mem_access_sequencer_pkg;

    localparam int LINE_BYTES = 16;

    typedef enum logic [1:0] {
        SZ_1B = 2'b00,
        SZ_2B = 2'b01,
        SZ_4B = 2'b10,
        SZ_8B = 2'b11
    } size_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD1,
        ST_RDW1,
        ST_RD2,
        ST_RDW2,
        ST_WR1,
        ST_WR2,
        ST_DONE,
        ST_DRAIN
    } state_e;

    // All-ones in the low n bytes (n <= 8).
    function automatic logic [63:0] byte_mask(input logic [3:0] n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (4'(i) < n) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

endpackage

// File: rtl/mem_split_calc.sv
// Splits an access into at most two line-contained pieces and shifts the store
// data for the second piece.
module mem_split_calc
    import mem_access_sequencer_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [63:0] wdata,
    output logic [3:0]  nbytes,
    output logic        split,
    output logic [3:0]  n1,
    output logic [3:0]  n2,
    output logic [31:0] addr2,
    output logic [63:0] wdata2
);

    logic [4:0] end_off;
    logic [4:0] room;

    always_comb begin
        nbytes = 4'd1;
        unique case (size_e'(size))
            SZ_1B: nbytes = 4'd1;
            SZ_2B: nbytes = 4'd2;
            SZ_4B: nbytes = 4'd4;
            SZ_8B: nbytes = 4'd8;
        endcase
    end

    assign end_off = {1'b0, addr[3:0]} + {1'b0, nbytes};
    assign room    = 5'(LINE_BYTES) - {1'b0, addr[3:0]};
    assign split   = end_off > 5'(LINE_BYTES);
    // When split the offset is at least 9, so the room left fits in 4 bits.
    assign n1      = split ? room[3:0] : nbytes;
    assign n2      = nbytes - n1;
    assign addr2   = {addr[31:4] + 28'd1, 4'b0000};
    assign wdata2  = wdata >> {n1, 3'b000};

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences an AG-stage memory access into one or two cache requests per
// direction, handling line splits, read-modify-write and pipeline flushes.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        V,
    input  logic        RD,
    input  logic        WR,
    input  logic [31:0] ADDR,
    input  logic [1:0]  SIZE,
    input  logic [63:0] WDATA,
    input  logic        FLUSH,
    output logic        C_REQ_V,
    input  logic        C_REQ_RDY,
    output logic [31:0] C_ADDR,
    output logic        C_RW,
    output logic [3:0]  C_BYTES,
    output logic [63:0] C_WDATA,
    input  logic        C_RESP_V,
    input  logic [63:0] C_RESP_DATA,
    output logic [63:0] RDATA,
    output logic        DONE,
    output logic        STALL
);

    state_e      state, state_nx;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [63:0] wdata_q;
    logic        wr_q;
    logic [63:0] rdata_q;

    logic [3:0]  nbytes, n1, n2;
    logic        split;
    logic [31:0] addr2;
    logic [63:0] wdata2;
    logic        accept, req_state, hs;

    mem_split_calc u_split (
        .addr   (addr_q),
        .size   (size_q),
        .wdata  (wdata_q),
        .nbytes (nbytes),
        .split  (split),
        .n1     (n1),
        .n2     (n2),
        .addr2  (addr2),
        .wdata2 (wdata2)
    );

    assign accept    = (state == ST_IDLE) & V & (RD | WR) & ~FLUSH;
    assign req_state = (state == ST_RD1) | (state == ST_RD2) |
                       (state == ST_WR1) | (state == ST_WR2);
    assign hs        = req_state & C_REQ_RDY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        C_ADDR   = '0;
        C_RW     = 1'b0;
        C_BYTES  = '0;
        C_WDATA  = '0;
        case (state)
            ST_IDLE:  if (accept) state_nx = RD ? ST_RD1 : ST_WR1;
            // A read handshaken in the same cycle as a flush still owes a response.
            ST_RD1: begin
                C_ADDR  = addr_q;
                C_BYTES = n1;
                if (hs)         state_nx = FLUSH ? ST_DRAIN : ST_RDW1;
                else if (FLUSH) state_nx = ST_IDLE;
            end
            ST_RD2: begin
                C_ADDR  = addr2;
                C_BYTES = n2;
                if (hs)         state_nx = FLUSH ? ST_DRAIN : ST_RDW2;
                else if (FLUSH) state_nx = ST_IDLE;
            end
            // A response coinciding with the flush leaves nothing to drain.
            ST_RDW1: begin
                if (C_RESP_V)   state_nx = FLUSH ? ST_IDLE :
                                           split ? ST_RD2 : wr_q ? ST_WR1 : ST_DONE;
                else if (FLUSH) state_nx = ST_DRAIN;
            end
            ST_RDW2: begin
                if (C_RESP_V)   state_nx = FLUSH ? ST_IDLE : wr_q ? ST_WR1 : ST_DONE;
                else if (FLUSH) state_nx = ST_DRAIN;
            end
            ST_WR1: begin
                C_ADDR  = addr_q;
                C_RW    = 1'b1;
                C_BYTES = n1;
                C_WDATA = wdata_q;
                if (FLUSH)   state_nx = ST_IDLE;
                else if (hs) state_nx = split ? ST_WR2 : ST_DONE;
            end
            ST_WR2: begin
                C_ADDR  = addr2;
                C_RW    = 1'b1;
                C_BYTES = n2;
                C_WDATA = wdata2;
                if (FLUSH)   state_nx = ST_IDLE;
                else if (hs) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            // Flush has nothing further to cancel here; the response is still owed.
            ST_DRAIN: if (C_RESP_V) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= ADDR;
            size_q  <= SIZE;
            wdata_q <= WDATA;
            wr_q    <= WR;
            rdata_q <= '0;
        end else if (C_RESP_V && !FLUSH) begin
            if (state == ST_RDW1)
                rdata_q <= C_RESP_DATA & byte_mask(n1);
            else if (state == ST_RDW2)
                rdata_q <= rdata_q | ((C_RESP_DATA & byte_mask(n2)) << {n1, 3'b000});
        end
    end

    assign C_REQ_V = req_state;
    assign RDATA   = rdata_q;
    assign DONE    = (state == ST_DONE);
    assign STALL   = ~((state == ST_IDLE) | (state == ST_DONE) | (state == ST_DRAIN)) | accept;

endmodule
